// File: rtl/eth_pkg.sv
// eth_pkg
// Shared types, frame-geometry constants and CRC-32 helper functions for the
// Ethernet dibit (RMII-style, 2 bits per clock) transmit and receive paths.
// No ports: this is a package imported by ether_tx_framer and crc32_dibit.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    DRAIN,
    GAP
  } eth_state_t;

  localparam logic [47:0] ALL_DEST       = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MY_MAC_DEFAULT = 48'h6969_5A06_5491;

  // Short per-phase counts fit the 6-bit phase counter.
  localparam logic [5:0]  HDR_DIBITS = 6'd56;
  localparam logic [5:0]  FCS_DIBITS = 6'd16;
  localparam logic [5:0]  IFG_CYCLES = 6'd48;

  // Payload lengths are measured on the 13-bit payload counter.
  localparam logic [12:0] MIN_PAYLOAD_DIBITS = 13'd184;
  localparam logic [12:0] MAX_PAYLOAD_DIBITS = 13'd6000;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  // One step of a non-reflected CRC-32 for a single input bit.
  function automatic logic [31:0] crc32Bit(input logic [31:0] crc, input logic b);
    logic [31:0] shifted;
    shifted = {crc[30:0], 1'b0};
    return (crc[31] ^ b) ? (shifted ^ CRC32_POLY) : shifted;
  endfunction

  // Two bits per clock: the more-significant bit of the dibit enters first,
  // matching the order in which dibits are put on the wire.
  function automatic logic [31:0] crc32Dibit(input logic [31:0] crc, input logic [1:0] dibit);
    return crc32Bit(crc32Bit(crc, dibit[1]), dibit[0]);
  endfunction

  // A payload(+pad) length is acceptable for closing the frame when it has
  // reached the minimum and keeps the frame on a whole-byte boundary.
  function automatic logic frameLenOk(input logic [12:0] n);
    return (n >= MIN_PAYLOAD_DIBITS) && (n[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit
// Running CRC-32 (poly 04C11DB7, init FFFFFFFF, not reflected, not inverted)
// consuming one dibit per enabled clock. Usable by both transmit FCS
// generation and receive-side FCS checking.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset, loads the init value
//   i_enable - fold i_dibit into the CRC this cycle
//   i_clear  - reload the init value (has priority over i_enable)
//   i_dibit  - data dibit, bit 1 most significant
//   o_crc    - current running CRC register
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic [1:0]  i_dibit,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= CRC32_INIT;
    end else if (i_clear) begin
      r_crc <= CRC32_INIT;
    end else if (i_enable) begin
      r_crc <= crc32Dibit(r_crc, i_dibit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ether_tx_framer.sv
// ether_tx_framer
// Wraps a dibit payload stream into an Ethernet frame: 56-dibit header
// (destination MAC, source MAC, ethertype), zero-latency payload
// pass-through, zero padding up to the minimum frame size, 16-dibit FCS,
// followed by a 48-cycle inter-frame gap. Underruns abort the frame without
// FCS; oversize payloads are cut at the maximum, closed with an FCS, and the
// remainder of the source frame is drained.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   axiiv  - payload dibit valid
//   axiid  - payload dibit
//   axiil  - last payload dibit of the frame
//   axiir  - ready; a dibit transfers when axiiv && axiir
//   axiov  - output dibit valid, continuous for the whole frame
//   axiod  - output dibit, zero whenever axiov is low
//   busy   - high whenever the framer is not idle
//   err    - single-cycle pulse on underrun or oversize
module ether_tx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC  = ALL_DEST,
  parameter logic [47:0] MY_MAC    = MY_MAC_DEFAULT,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy,
  output logic       err
);

  eth_state_t  r_state;
  eth_state_t  w_nextState;
  logic [5:0]  r_cnt;
  logic [5:0]  w_nextCnt;
  logic [12:0] r_payCnt;
  logic [12:0] w_nextPayCnt;
  logic        r_oversize;
  logic        w_nextOversize;

  logic        w_crcEn;
  logic        w_crcClear;
  logic [1:0]  w_crcDibit;
  logic [31:0] w_crc;

  logic [111:0] w_hdr;
  logic [6:0]   w_hdrIdx;
  logic [1:0]   w_hdrDibit;
  logic [31:0]  w_fcs;
  logic [4:0]   w_fcsIdx;
  logic [1:0]   w_fcsDibit;
  logic [12:0]  w_payInc;

  // Header and FCS are read most-significant dibit first by indexing with the
  // phase counter, so no shift registers are needed.
  assign w_hdr      = {DEST_MAC, MY_MAC, ETHERTYPE};
  assign w_hdrIdx   = 7'd111 - {r_cnt, 1'b0};
  assign w_hdrDibit = w_hdr[w_hdrIdx -: 2];
  assign w_fcs      = ~w_crc;
  assign w_fcsIdx   = 5'd31 - {r_cnt[3:0], 1'b0};
  assign w_fcsDibit = w_fcs[w_fcsIdx -: 2];
  assign w_payInc   = r_payCnt + 13'd1;

  // The CRC is reseeded every idle cycle so each frame starts fresh.
  assign w_crcClear = (r_state == IDLE);

  crc32_dibit u_crc (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_enable (w_crcEn),
    .i_clear  (w_crcClear),
    .i_dibit  (w_crcDibit),
    .o_crc    (w_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_payCnt   <= '0;
      r_oversize <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_payCnt   <= w_nextPayCnt;
      r_oversize <= w_nextOversize;
    end
  end

  // Next-state and output decode. Outputs are purely combinational from
  // state and inputs so that payload passes through in the same cycle and
  // reset silences every output immediately.
  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    w_nextPayCnt   = r_payCnt;
    w_nextOversize = r_oversize;
    axiir          = 1'b0;
    axiov          = 1'b0;
    axiod          = 2'b00;
    busy           = 1'b1;
    err            = 1'b0;
    w_crcEn        = 1'b0;
    w_crcDibit     = 2'b00;

    case (r_state)
      IDLE: begin
        busy           = 1'b0;
        w_nextCnt      = '0;
        w_nextPayCnt   = '0;
        w_nextOversize = 1'b0;
        // The waiting dibit is not consumed here; it is taken in PAYLOAD.
        if (axiiv) begin
          w_nextState = HEADER;
        end
      end

      HEADER: begin
        axiov      = 1'b1;
        axiod      = w_hdrDibit;
        w_crcEn    = 1'b1;
        w_crcDibit = w_hdrDibit;
        if (r_cnt == HDR_DIBITS - 6'd1) begin
          w_nextCnt   = '0;
          w_nextState = PAYLOAD;
        end else begin
          w_nextCnt = r_cnt + 6'd1;
        end
      end

      PAYLOAD: begin
        axiir = 1'b1;
        if (axiiv) begin
          axiov        = 1'b1;
          axiod        = axiid;
          w_crcEn      = 1'b1;
          w_crcDibit   = axiid;
          w_nextPayCnt = w_payInc;
          if (axiil) begin
            w_nextState = frameLenOk(w_payInc) ? FCS : PAD;
          end else if (w_payInc == MAX_PAYLOAD_DIBITS) begin
            // Close the frame legally, then discard what the source still has.
            err            = 1'b1;
            w_nextOversize = 1'b1;
            w_nextState    = FCS;
          end
        end else begin
          // Underrun: a gap inside a frame cannot be repaired, so abort it.
          err         = 1'b1;
          w_nextCnt   = '0;
          w_nextState = GAP;
        end
      end

      PAD: begin
        axiov        = 1'b1;
        w_crcEn      = 1'b1;
        w_nextPayCnt = w_payInc;
        if (frameLenOk(w_payInc)) begin
          w_nextState = FCS;
        end
      end

      FCS: begin
        axiov = 1'b1;
        axiod = w_fcsDibit;
        if (r_cnt == FCS_DIBITS - 6'd1) begin
          w_nextCnt   = '0;
          w_nextState = r_oversize ? DRAIN : GAP;
        end else begin
          w_nextCnt = r_cnt + 6'd1;
        end
      end

      DRAIN: begin
        axiir     = 1'b1;
        w_nextCnt = '0;
        if (axiiv && axiil) begin
          w_nextState = GAP;
        end
      end

      GAP: begin
        if (r_cnt == IFG_CYCLES - 6'd1) begin
          w_nextCnt   = '0;
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_cnt + 6'd1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ether_tx_framer.sv
// tb_ether_tx_framer
// Directed bench for ether_tx_framer. Expected output dibits are queued when
// a frame is launched; a negedge monitor pops and compares every dibit the
// framer presents with axiov high, and tracks run lengths, gaps, err pulses
// and drained dibits for the per-frame checks.
module tb_ether_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiil = 1'b0;
  logic       axiir;
  logic       axiov;
  logic [1:0] axiod;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [1:0] expQ[$];
  logic [1:0] capQ[$];
  logic [1:0] payQ[$];

  int cyc = 0;
  int errSeen = 0;
  int curRun = 0;
  int lastRun = 0;
  int curGap = 0;
  int lastGap = 0;
  int drainCnt = 0;
  int firstOvCycle = -1;
  int ivRiseCycle = 0;
  int acceptCnt = 0;

  always #5 clk = ~clk;

  ether_tx_framer dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiil (axiil),
    .axiir (axiir),
    .axiov (axiov),
    .axiod (axiod),
    .busy  (busy),
    .err   (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples away from the active edge and scores every valid dibit.
  always @(negedge clk) begin
    logic [1:0] expD;
    if (!rst) begin
      checks++;
      if (axiov || axiir || busy || err || (axiod != 2'b00)) begin
        errors++;
        $display("[TB] FAIL reset_outputs: axiov=%0b axiir=%0b busy=%0b err=%0b axiod=%0d, required all 0",
                 axiov, axiir, busy, err, axiod);
      end
      curRun = 0;
      curGap = 0;
    end else begin
      if (err) errSeen++;
      if (busy && !axiov && axiir && axiiv) drainCnt++;
      if (axiov) begin
        if (curRun == 0 && firstOvCycle < 0) firstOvCycle = cyc;
        curRun++;
        capQ.push_back(axiod);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_dibit: got %0d at frame index %0d, required no output",
                   axiod, capQ.size() - 1);
        end else begin
          expD = expQ.pop_front();
          if (axiod !== expD) begin
            errors++;
            $display("[TB] FAIL dibit[%0d]: got %0d required %0d", capQ.size() - 1, axiod, expD);
          end
        end
      end else begin
        if (curRun != 0) begin
          lastRun = curRun;
          curRun = 0;
        end
        checks++;
        if (axiod !== 2'b00) begin
          errors++;
          $display("[TB] FAIL idle_axiod: got %0d required 0", axiod);
        end
      end
      if (busy && !axiov && !axiir) begin
        curGap++;
      end else if (curGap != 0) begin
        lastGap = curGap;
        curGap = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int required);
    checks++;
    if (got != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, required);
    end
  endtask

  task automatic fillPayload(input int n, input int seed);
    payQ.delete();
    for (int i = 0; i < n; i++) begin
      payQ.push_back(2'((i * 3 + seed + (i >> 4)) & 3));
    end
  endtask

  // Reference frame: header from literal constants, payload, optional zero
  // pad, and an FCS from a bit-serial CRC-32 over the whole emitted stream.
  task automatic pushExpected(input int nPay, input bit withPad, input bit withFcs);
    logic [111:0] hdr;
    logic [1:0]   frame[$];
    logic [31:0]  crc;
    logic [31:0]  fcs;
    logic [1:0]   d;
    logic         fb;
    int           total;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h6969_5A06_5491, 16'h88B5};
    for (int i = 0; i < 56; i++) frame.push_back(hdr[111 - 2 * i -: 2]);
    for (int i = 0; i < nPay; i++) frame.push_back(payQ[i]);
    if (withPad) begin
      total = nPay;
      while (total < 184 || (total % 4) != 0) begin
        frame.push_back(2'b00);
        total++;
      end
    end
    crc = 32'hFFFF_FFFF;
    foreach (frame[k]) begin
      d = frame[k];
      expQ.push_back(d);
      for (int b = 1; b >= 0; b--) begin
        fb  = crc[31] ^ d[b];
        crc = crc << 1;
        if (fb) crc = crc ^ 32'h04C1_1DB7;
      end
    end
    if (withFcs) begin
      fcs = ~crc;
      for (int i = 0; i < 16; i++) expQ.push_back(fcs[31 - 2 * i -: 2]);
    end
  endtask

  // Source: presents payQ[0..n-1] and advances on each accepted transfer.
  task automatic applyStimulus(input int n, input bit withLast);
    int  idx;
    int  budget;
    bit  acc;
    idx = 0;
    budget = 0;
    acceptCnt = 0;
    @(posedge clk); #1;
    axiiv = 1'b1;
    axiid = payQ[0];
    axiil = withLast && (n == 1);
    ivRiseCycle = cyc;
    while (idx < n) begin
      @(negedge clk);
      acc = axiiv && axiir;
      @(posedge clk); #1;
      budget++;
      if (acc) begin
        idx++;
        acceptCnt++;
        if (idx < n) begin
          axiid = payQ[idx];
          axiil = withLast && (idx == n - 1);
        end
      end
      if (budget > n + 1000) begin
        checks++;
        errors++;
        $display("[TB] FAIL stimulus_timeout: accepted %0d required %0d", idx, n);
        break;
      end
    end
    axiiv = 1'b0;
    axiil = 1'b0;
    axiid = 2'b00;
  endtask

  task automatic waitIdle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("busy_clears_in_budget", int'(i < budget), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic startFrame();
    capQ.delete();
    firstOvCycle = -1;
    lastRun = 0;
    lastGap = 0;
    drainCnt = 0;
  endtask

  // Full 184-dibit frame with hand-derived header spot checks.
  task automatic runMinFrame(input string tag);
    int errBase;
    int hand[12];
    int et[8];
    hand = '{1, 2, 2, 1, 1, 2, 2, 1, 1, 1, 2, 2};
    et   = '{2, 0, 2, 0, 2, 3, 1, 1};
    fillPayload(184, 0);
    pushExpected(184, 1'b1, 1'b1);
    startFrame();
    errBase = errSeen;
    applyStimulus(184, 1'b1);
    waitIdle(400);
    checkOutput({tag, "_leftover"}, expQ.size(), 0);
    checkOutput({tag, "_axiov_run"}, lastRun, 256);
    checkOutput({tag, "_captured"}, capQ.size(), 256);
    checkOutput({tag, "_gap"}, lastGap, 48);
    checkOutput({tag, "_err"}, errSeen - errBase, 0);
    checkOutput({tag, "_hdr_latency"}, firstOvCycle - ivRiseCycle, 1);
    if (capQ.size() >= 56) begin
      checkOutput({tag, "_dest_first"}, int'(capQ[0]), 3);
      for (int i = 0; i < 12; i++) checkOutput({tag, "_src_dibit"}, int'(capQ[24 + i]), hand[i]);
      for (int i = 0; i < 8; i++) checkOutput({tag, "_type_dibit"}, int'(capQ[48 + i]), et[i]);
    end
    expQ.delete();
  endtask

  initial begin
    int errBase;
    int zeros;
    int waitCnt;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Quiet interface after reset.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idle_quiet", int'({axiov, axiir, busy}), 0);
    end

    runMinFrame("min184");

    // Short payload padded with zeros.
    fillPayload(10, 1);
    pushExpected(10, 1'b1, 1'b1);
    startFrame();
    errBase = errSeen;
    applyStimulus(10, 1'b1);
    waitIdle(400);
    checkOutput("pad10_leftover", expQ.size(), 0);
    checkOutput("pad10_axiov_run", lastRun, 256);
    checkOutput("pad10_gap", lastGap, 48);
    checkOutput("pad10_err", errSeen - errBase, 0);
    zeros = 0;
    if (capQ.size() >= 240) for (int i = 66; i < 240; i++) if (capQ[i] == 2'b00) zeros++;
    checkOutput("pad10_zero_dibits", zeros, 174);
    expQ.delete();

    // Underrun after 50 payload dibits.
    fillPayload(50, 2);
    pushExpected(50, 1'b0, 1'b0);
    startFrame();
    errBase = errSeen;
    applyStimulus(50, 1'b0);
    waitIdle(200);
    checkOutput("underrun_leftover", expQ.size(), 0);
    checkOutput("underrun_axiov_run", lastRun, 106);
    checkOutput("underrun_err", errSeen - errBase, 1);
    checkOutput("underrun_gap", lastGap, 48);
    expQ.delete();

    // Oversize: 6010 dibits, only 6000 framed, remainder drained.
    fillPayload(6010, 3);
    pushExpected(6000, 1'b0, 1'b1);
    startFrame();
    errBase = errSeen;
    applyStimulus(6010, 1'b1);
    waitIdle(400);
    checkOutput("oversize_leftover", expQ.size(), 0);
    checkOutput("oversize_axiov_run", lastRun, 6072);
    checkOutput("oversize_err", errSeen - errBase, 1);
    checkOutput("oversize_accepted", acceptCnt, 6010);
    checkOutput("oversize_drained", drainCnt, 10);
    checkOutput("oversize_gap", lastGap, 48);
    expQ.delete();

    // Reset in the middle of the header.
    fillPayload(0, 0);
    pushExpected(0, 1'b0, 1'b0);
    startFrame();
    @(posedge clk); #1;
    axiiv = 1'b1;
    axiid = 2'b11;
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (!axiov && waitCnt < 10);
    checkOutput("rst_hdr_started", int'(axiov), 1);
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    #1 checkOutput("rst_outputs_immediate", int'({axiov, axiir, busy, err, axiod}), 0);
    checkOutput("rst_hdr_dibits_seen", capQ.size(), 30);
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    checkOutput("rst_no_gap_after", int'(busy), 0);

    runMinFrame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
